// File: rtl/id_ex_stage_buf_pkg.sv
// Shared widths, control-field layout and buffer state encoding for the
// ID/EX stage skid buffer.
package id_ex_stage_buf_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int ADDR_W_DEF  = 5;
    localparam int ALUOP_W_DEF = 4;

    // Control word is {RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst, ALUOp}.
    localparam int CTRL_FLAG_CNT = 6;

    function automatic int ctrl_width(input int aluop_w);
        return CTRL_FLAG_CNT + aluop_w;
    endfunction

    localparam int CTRL_W_DEF = ctrl_width(ALUOP_W_DEF);

    // Bit positions within i_ctrl, given as offsets above the ALUOp field.
    localparam int CTRL_REGWRITE_OFS = 5;
    localparam int CTRL_MEMTOREG_OFS = 4;
    localparam int CTRL_MEMWRITE_OFS = 3;
    localparam int CTRL_MEMREAD_OFS  = 2;
    localparam int CTRL_ALUSRC_OFS   = 1;
    localparam int CTRL_REGDST_OFS   = 0;
    localparam int CTRL_ALUOP_LSB    = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload holding register with load enable and synchronous clear.
module pipe_payload_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] data_q;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            data_q <= '0;
        end else if (i_load) begin
            data_q <= i_d;
        end
    end

    assign o_q = data_q;

endmodule

// File: rtl/id_ex_stage_buf.sv
// ID/EX pipeline buffer: main register plus one skid entry so that o_ready
// can be registered without losing an instruction under back-pressure.
module id_ex_stage_buf
    import id_ex_stage_buf_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int ADDR_W  = ADDR_W_DEF,
    parameter  int ALUOP_W = ALUOP_W_DEF,
    localparam int CTRL_W  = ctrl_width(ALUOP_W)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_flush,
    input  logic [CTRL_W-1:0]   i_ctrl,
    input  logic [DATA_W-1:0]   i_pc4,
    input  logic [DATA_W-1:0]   i_rd1,
    input  logic [DATA_W-1:0]   i_rd2,
    input  logic [DATA_W-1:0]   i_imm,
    input  logic [3*ADDR_W-1:0] i_regaddr,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [CTRL_W-1:0]   o_ctrl,
    output logic [DATA_W-1:0]   o_pc4,
    output logic [DATA_W-1:0]   o_rd1,
    output logic [DATA_W-1:0]   o_rd2,
    output logic [DATA_W-1:0]   o_imm,
    output logic [ADDR_W-1:0]   o_rs,
    output logic [ADDR_W-1:0]   o_rt,
    output logic [ADDR_W-1:0]   o_rd
);

    localparam int PAY_W    = CTRL_W + 4 * DATA_W + 3 * ADDR_W;
    localparam int REG_LSB  = 0;
    localparam int IMM_LSB  = REG_LSB + 3 * ADDR_W;
    localparam int RD2_LSB  = IMM_LSB + DATA_W;
    localparam int RD1_LSB  = RD2_LSB + DATA_W;
    localparam int PC4_LSB  = RD1_LSB + DATA_W;
    localparam int CTRL_LSB = PC4_LSB + DATA_W;

    buf_state_e state_q, state_d;
    logic       ready_q;
    logic       accept, issue;
    logic       main_load, main_from_skid, skid_load;
    logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;

    assign in_pay = {i_ctrl, i_pc4, i_rd1, i_rd2, i_imm, i_regaddr};
    assign accept = i_valid && ready_q;
    assign issue  = o_valid && i_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d   = ST_ONE;
                        main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !issue) begin
                        state_d   = ST_TWO;
                        skid_load = 1'b1;
                    end else if (accept && issue) begin
                        main_load = 1'b1;
                    end else if (issue) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (issue) begin
                        state_d        = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // o_ready looks at the next state, so i_ready never reaches it combinationally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_TWO);
        end
    end

    assign main_d = main_from_skid ? skid_q : in_pay;

    pipe_payload_reg #(.W(PAY_W)) u_main (
        .i_clk  (i_clk),
        .i_clr  (!i_rst_n),
        .i_load (main_load),
        .i_d    (main_d),
        .o_q    (main_q)
    );

    pipe_payload_reg #(.W(PAY_W)) u_skid (
        .i_clk  (i_clk),
        .i_clr  (!i_rst_n),
        .i_load (skid_load),
        .i_d    (in_pay),
        .o_q    (skid_q)
    );

    assign o_ready = ready_q;
    assign o_valid = (state_q != ST_EMPTY);
    assign o_ctrl  = o_valid ? main_q[CTRL_LSB +: CTRL_W] : '0;
    assign o_pc4   = main_q[PC4_LSB +: DATA_W];
    assign o_rd1   = main_q[RD1_LSB +: DATA_W];
    assign o_rd2   = main_q[RD2_LSB +: DATA_W];
    assign o_imm   = main_q[IMM_LSB +: DATA_W];
    assign o_rs    = main_q[REG_LSB + 2 * ADDR_W +: ADDR_W];
    assign o_rt    = main_q[REG_LSB + ADDR_W +: ADDR_W];
    assign o_rd    = main_q[REG_LSB +: ADDR_W];

endmodule

// File: tb/tb_id_ex_stage_buf.sv
// Directed self-checking bench for id_ex_stage_buf, built with the wide
// 64-bit data / 6-bit register-specifier configuration.
module tb_id_ex_stage_buf;

    localparam int DW  = 64;
    localparam int AW  = 6;
    localparam int AOW = 4;
    localparam int CW  = 6 + AOW;

    logic            i_clk = 1'b0;
    logic            i_rst_n, i_valid, i_flush, i_ready;
    logic            o_ready, o_valid;
    logic [CW-1:0]   i_ctrl, o_ctrl;
    logic [DW-1:0]   i_pc4, i_rd1, i_rd2, i_imm;
    logic [DW-1:0]   o_pc4, o_rd1, o_rd2, o_imm;
    logic [3*AW-1:0] i_regaddr;
    logic [AW-1:0]   o_rs, o_rt, o_rd;

    int errors = 0;
    int checks = 0;

    id_ex_stage_buf #(.DATA_W(DW), .ADDR_W(AW), .ALUOP_W(AOW)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_flush   (i_flush),
        .i_ctrl    (i_ctrl),
        .i_pc4     (i_pc4),
        .i_rd1     (i_rd1),
        .i_rd2     (i_rd2),
        .i_imm     (i_imm),
        .i_regaddr (i_regaddr),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_ctrl    (o_ctrl),
        .o_pc4     (o_pc4),
        .o_rd1     (o_rd1),
        .o_rd2     (o_rd2),
        .o_imm     (o_imm),
        .o_rs      (o_rs),
        .o_rt      (o_rt),
        .o_rd      (o_rd)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [CW-1:0] ctrl,
                                 input logic [DW-1:0] pc4);
        i_valid = valid;
        i_ctrl  = ctrl;
        i_pc4   = pc4;
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkHandshake(input string tag, input logic expValid,
                                  input logic expReady, input logic [CW-1:0] expCtrl,
                                  input logic [DW-1:0] expPc4);
        checkOutput({tag, ".valid"}, DW'(o_valid), DW'(expValid));
        checkOutput({tag, ".ready"}, DW'(o_ready), DW'(expReady));
        checkOutput({tag, ".ctrl"},  DW'(o_ctrl),  DW'(expCtrl));
        checkOutput({tag, ".pc4"},   o_pc4,        expPc4);
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_flush   = 1'b0;
        i_ready   = 1'b0;
        i_rd1     = '0;
        i_rd2     = '0;
        i_imm     = '0;
        i_regaddr = '0;
        applyStimulus(1'b1, 10'h155, 64'h1234);

        // Reset held two cycles, even with an instruction offered.
        tick();
        tick();
        checkHandshake("reset", 1'b0, 1'b1, 10'h000, 64'h0);
        checkOutput("reset.rd1", o_rd1, 64'h0);
        checkOutput("reset.rd2", o_rd2, 64'h0);
        checkOutput("reset.imm", o_imm, 64'h0);
        checkOutput("reset.rs",  DW'(o_rs), 64'h0);
        checkOutput("reset.rt",  DW'(o_rt), 64'h0);
        checkOutput("reset.rd",  DW'(o_rd), 64'h0);

        // Streaming at full rate: each pc4 appears one cycle after its accept.
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        applyStimulus(1'b1, 10'h201, 64'h4);
        tick();
        checkHandshake("stream0", 1'b1, 1'b1, 10'h201, 64'h4);
        applyStimulus(1'b1, 10'h102, 64'h8);
        tick();
        checkHandshake("stream1", 1'b1, 1'b1, 10'h102, 64'h8);
        applyStimulus(1'b1, 10'h084, 64'hC);
        tick();
        checkHandshake("stream2", 1'b1, 1'b1, 10'h084, 64'hC);
        applyStimulus(1'b1, 10'h048, 64'h10);
        tick();
        checkHandshake("stream3", 1'b1, 1'b1, 10'h048, 64'h10);
        applyStimulus(1'b0, 10'h3FF, 64'hDEAD);
        tick();
        checkHandshake("streamIdle", 1'b0, 1'b1, 10'h000, 64'h10);

        // Back-pressure fills main then skid; draining preserves order.
        i_ready = 1'b0;
        applyStimulus(1'b1, 10'h011, 64'h4);
        tick();
        checkHandshake("bpOne", 1'b1, 1'b1, 10'h011, 64'h4);
        applyStimulus(1'b1, 10'h022, 64'h8);
        tick();
        checkHandshake("bpTwo", 1'b1, 1'b0, 10'h011, 64'h4);
        applyStimulus(1'b1, 10'h033, 64'hC);
        i_ready = 1'b1;
        tick();
        checkHandshake("bpDrain1", 1'b1, 1'b1, 10'h022, 64'h8);
        applyStimulus(1'b0, 10'h000, 64'h0);
        tick();
        checkHandshake("bpDrain2", 1'b0, 1'b1, 10'h000, 64'h8);

        // Flush in state TWO drops both held entries and the incoming one.
        i_ready = 1'b0;
        applyStimulus(1'b1, 10'h0A0, 64'h20);
        tick();
        applyStimulus(1'b1, 10'h0B0, 64'h24);
        tick();
        checkHandshake("flushPre", 1'b1, 1'b0, 10'h0A0, 64'h20);
        i_flush = 1'b1;
        applyStimulus(1'b1, 10'h0C0, 64'h28);
        tick();
        checkHandshake("flush", 1'b0, 1'b1, 10'h000, 64'h20);
        i_flush = 1'b0;
        i_ready = 1'b1;
        applyStimulus(1'b0, 10'h000, 64'h0);
        tick();
        checkHandshake("flushAfter", 1'b0, 1'b1, 10'h000, 64'h20);

        // All-ones control passes, then becomes a bubble while pc4 holds.
        applyStimulus(1'b1, 10'h3FF, 64'h30);
        tick();
        checkHandshake("ctrlOnes", 1'b1, 1'b1, 10'h3FF, 64'h30);
        applyStimulus(1'b0, 10'h3FF, 64'h34);
        tick();
        checkHandshake("ctrlBubble", 1'b0, 1'b1, 10'h000, 64'h30);

        // Wide payload fields pass through bit-exact.
        i_rd1     = 64'hFFFF_FFFF_0000_0001;
        i_rd2     = 64'h8000_0000_0000_0000;
        i_imm     = 64'hFFFF_FFFF_FFFF_FFFE;
        i_regaddr = {6'h15, 6'h2A, 6'h3F};
        applyStimulus(1'b1, 10'h1C3, 64'hCAFE_F00D_0000_0044);
        tick();
        checkHandshake("wide", 1'b1, 1'b1, 10'h1C3, 64'hCAFE_F00D_0000_0044);
        checkOutput("wide.rd1", o_rd1, 64'hFFFF_FFFF_0000_0001);
        checkOutput("wide.rd2", o_rd2, 64'h8000_0000_0000_0000);
        checkOutput("wide.imm", o_imm, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("wide.rs",  DW'(o_rs), 64'h15);
        checkOutput("wide.rt",  DW'(o_rt), 64'h2A);
        checkOutput("wide.rd",  DW'(o_rd), 64'h3F);

        // Reset mid-operation in TWO wins over a simultaneous flush.
        i_ready = 1'b0;
        applyStimulus(1'b1, 10'h2F0, 64'h50);
        tick();
        checkHandshake("rstPre", 1'b1, 1'b0, 10'h1C3, 64'hCAFE_F00D_0000_0044);
        i_rst_n = 1'b0;
        i_flush = 1'b1;
        tick();
        checkHandshake("rstMid", 1'b0, 1'b1, 10'h000, 64'h0);
        checkOutput("rstMid.rd1", o_rd1, 64'h0);
        checkOutput("rstMid.rd",  DW'(o_rd), 64'h0);
        i_rst_n = 1'b1;
        i_flush = 1'b0;
        i_ready = 1'b1;
        applyStimulus(1'b0, 10'h000, 64'h0);
        tick();
        checkHandshake("rstAfter", 1'b0, 1'b1, 10'h000, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
